// File: rtl/mac_cplx_vec.sv
// Complex vector multiply-accumulate.
// Each operation multiplies LANES complex element pairs (x*y) one lane per
// clock and adds the products into a pair of signed accumulators.
// Optional feature: define MAC_CPLX_SAT_EN to make the accumulators saturate
// on overflow instead of wrapping. Overflow is always flagged on the sticky ovf.
module mac_cplx_vec #(
   parameter int LANES = 4,
   parameter int DW    = 4,
   parameter int ACC_W = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    accum,
   input  logic [LANES*2*DW-1:0]   x_in,
   input  logic [LANES*2*DW-1:0]   y_in,
   output logic                    ready,
   output logic                    done,
   output logic                    ovf,
   output logic [ACC_W-1:0]        acc_re,
   output logic [ACC_W-1:0]        acc_im
);

   localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int EW = ACC_W + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                  state;
   logic [LANES*2*DW-1:0]   x_r;
   logic [LANES*2*DW-1:0]   y_r;
   logic [CW-1:0]           cnt;

   logic signed [DW-1:0]    xr, xi, yr, yi;
   logic signed [EW-1:0]    prod_re, prod_im;
   logic signed [EW-1:0]    sum_re, sum_im;
   logic                    ovf_re, ovf_im;
   logic [ACC_W-1:0]        nxt_re, nxt_im;

   // Select the real/imag parts of the lane addressed by the lane counter
   always_comb begin
      xr = '0;
      xi = '0;
      yr = '0;
      yi = '0;
      for (int k = 0; k < LANES; k++) begin
         if (cnt == CW'(k)) begin
            xr = x_r[2*DW*k +: DW];
            xi = x_r[2*DW*k+DW +: DW];
            yr = y_r[2*DW*k +: DW];
            yi = y_r[2*DW*k+DW +: DW];
         end
      end
   end

   // Complex product and accumulator sums one bit wider than the accumulator,
   // so the extra top bit exposes any overflow of the signed ACC_W range
   always_comb begin
      prod_re = EW'(xr) * EW'(yr) - EW'(xi) * EW'(yi);
      prod_im = EW'(xr) * EW'(yi) + EW'(xi) * EW'(yr);
      sum_re  = EW'($signed(acc_re)) + prod_re;
      sum_im  = EW'($signed(acc_im)) + prod_im;
      ovf_re  = sum_re[EW-1] ^ sum_re[EW-2];
      ovf_im  = sum_im[EW-1] ^ sum_im[EW-2];
   end

   // Next accumulator value: clamp toward the true sign on overflow, or wrap
   always_comb begin
`ifdef MAC_CPLX_SAT_EN
      if (ovf_re)
         nxt_re = sum_re[EW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      else
         nxt_re = sum_re[ACC_W-1:0];
      if (ovf_im)
         nxt_im = sum_im[EW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      else
         nxt_im = sum_im[ACC_W-1:0];
`else
      nxt_re = sum_re[ACC_W-1:0];
      nxt_im = sum_im[ACC_W-1:0];
`endif
   end

   // Control FSM with registered outputs; operands are frozen at capture so
   // later input changes cannot disturb a running operation
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         cnt    <= '0;
         x_r    <= '0;
         y_r    <= '0;
         acc_re <= '0;
         acc_im <= '0;
         ovf    <= 1'b0;
         done   <= 1'b0;
         ready  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  x_r   <= x_in;
                  y_r   <= y_in;
                  cnt   <= '0;
                  ready <= 1'b0;
                  state <= RUN;
                  if (!accum) begin
                     acc_re <= '0;
                     acc_im <= '0;
                     ovf    <= 1'b0;
                  end
               end
            end
            RUN: begin
               acc_re <= nxt_re;
               acc_im <= nxt_im;
               if (ovf_re || ovf_im)
                  ovf <= 1'b1;
               if (cnt == CW'(LANES-1)) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mac_cplx_vec.sv
// Self-checking bench for mac_cplx_vec (default parameters).
// A behavioural model predicts each result when the DUT captures an
// operation; the prediction is queued and compared when done pulses.
// Honours MAC_CPLX_SAT_EN the same way the design does.
module tb_mac_cplx_vec;

   localparam int LANES = 4;
   localparam int DW    = 4;
   localparam int ACC_W = 10;
   localparam int VW    = LANES*2*DW;
   localparam int MAXV  = 2**(ACC_W-1) - 1;
   localparam int MINV  = -(2**(ACC_W-1));

   logic                     clk;
   logic                     rst;
   logic                     start;
   logic                     accum;
   logic [VW-1:0]            x_in;
   logic [VW-1:0]            y_in;
   logic                     ready;
   logic                     done;
   logic                     ovf;
   logic signed [ACC_W-1:0]  acc_re;
   logic signed [ACC_W-1:0]  acc_im;

   typedef struct {
      int re;
      int im;
      int ovf;
      int cap;
   } exp_t;

   exp_t exp_q[$];

   int check_cnt = 0;
   int pass_cnt  = 0;
   int done_cnt  = 0;
   int cyc       = 0;
   int m_re      = 0;
   int m_im      = 0;
   int m_ovf     = 0;
   int prev_cap  = 0;
   int ready_since = 0;
   bit have_prev = 0;
   bit btb_mode  = 0;

   mac_cplx_vec #(.LANES(LANES), .DW(DW), .ACC_W(ACC_W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .accum  (accum),
      .x_in   (x_in),
      .y_in   (y_in),
      .ready  (ready),
      .done   (done),
      .ovf    (ovf),
      .acc_re (acc_re),
      .acc_im (acc_im)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input int obs, input int exp);
      check_cnt++;
      if (obs == exp) begin
         pass_cnt++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Same value in every lane
   function automatic logic [VW-1:0] pack_all(input int re, input int im);
      logic [VW-1:0] v;
      v = '0;
      for (int k = 0; k < LANES; k++) begin
         v[2*DW*k +: DW]    = DW'(re);
         v[2*DW*k+DW +: DW] = DW'(im);
      end
      return v;
   endfunction

   function automatic logic [VW-1:0] rand_vec();
      logic [VW-1:0] v;
      v = '0;
      for (int k = 0; k < 2*LANES; k++)
         v[DW*k +: DW] = DW'($urandom);
      return v;
   endfunction

   // Accumulator addition with range tracking and wrap/clamp behaviour
   function automatic int add_part(input int a, input int p, inout int o);
      int s;
      s = a + p;
      if (s > MAXV || s < MINV) begin
         o = 1;
`ifdef MAC_CPLX_SAT_EN
         s = (s > MAXV) ? MAXV : MINV;
`else
         while (s > MAXV) s -= 2**ACC_W;
         while (s < MINV) s += 2**ACC_W;
`endif
      end
      return s;
   endfunction

   function automatic int part(input logic [VW-1:0] v, input int k, input int hi);
      logic signed [DW-1:0] t;
      t = v[2*DW*k + hi*DW +: DW];
      return int'(t);
   endfunction

   // Model one whole operation against the running model accumulators
   task automatic model_op(input logic [VW-1:0] x, input logic [VW-1:0] y, input logic acc_in);
      int xr, xi, yr, yi;
      if (!acc_in) begin
         m_re  = 0;
         m_im  = 0;
         m_ovf = 0;
      end
      for (int k = 0; k < LANES; k++) begin
         xr = part(x, k, 0);
         xi = part(x, k, 1);
         yr = part(y, k, 0);
         yi = part(y, k, 1);
         m_re = add_part(m_re, xr*yr - xi*yi, m_ovf);
         m_im = add_part(m_im, xr*yi + xi*yr, m_ovf);
      end
   endtask

   // Scoreboard: predict at capture edges, compare on done at the falling edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         if (!btb_mode)
            have_prev = 0;
         if (!rst) begin
            exp_q.delete();
            m_re  = 0;
            m_im  = 0;
            m_ovf = 0;
         end else if (ready && start) begin
            model_op(x_in, y_in, accum);
            e.re  = m_re;
            e.im  = m_im;
            e.ovf = m_ovf;
            e.cap = cyc;
            exp_q.push_back(e);
            if (btb_mode && have_prev) begin
               checkOutput("btb_interval", cyc - prev_cap, LANES + 2);
               checkOutput("btb_ready_cycles", ready_since, 1);
            end
            prev_cap    = cyc;
            have_prev   = 1;
            ready_since = 0;
         end
         cyc++;
         @(negedge clk);
         if (ready)
            ready_since++;
         if (done) begin
            done_cnt++;
            checkOutput("sb_pending", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               checkOutput("sb_acc_re", int'(acc_re), e.re);
               checkOutput("sb_acc_im", int'(acc_im), e.im);
               checkOutput("sb_ovf", int'(ovf), e.ovf);
               checkOutput("sb_latency", cyc - e.cap - 1, LANES);
            end
         end
      end
   end

   // Wait (bounded) for n more done pulses
   task automatic wait_dones(input int n, input string tag);
      int base;
      base = done_cnt;
      for (int i = 0; i < 20*n && (done_cnt - base) < n; i++) begin
         @(negedge clk);
         #1;
      end
      checkOutput({tag, "_dones"}, done_cnt - base, n);
   endtask

   // One complete operation; returns two cycles after done so hold is exercised
   task automatic applyStimulus(input logic [VW-1:0] x, input logic [VW-1:0] y, input logic acc_in, input string tag);
      @(negedge clk);
      #1;
      x_in  = x;
      y_in  = y;
      accum = acc_in;
      start = 1'b1;
      @(negedge clk);
      #1;
      start = 1'b0;
      wait_dones(1, tag);
      repeat (2) @(negedge clk);
      #1;
   endtask

   // Watchdog so the run can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Directed sequence
   initial begin
      int base;
      rst   = 1'b0;
      start = 1'b0;
      accum = 1'b0;
      x_in  = '0;
      y_in  = '0;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset_acc_re", int'(acc_re), 0);
      checkOutput("reset_acc_im", int'(acc_im), 0);
      checkOutput("reset_ovf", int'(ovf), 0);
      checkOutput("reset_done", int'(done), 0);
      checkOutput("reset_ready", int'(ready), 1);
      rst = 1'b1;

      $display("[TB] basic / accumulate");
      applyStimulus(pack_all(1, 2), pack_all(3, 1), 1'b0, "basic");
      checkOutput("basic_re", int'(acc_re), 4);
      checkOutput("basic_im", int'(acc_im), 28);
      checkOutput("basic_ovf", int'(ovf), 0);
      checkOutput("basic_ready", int'(ready), 1);
      applyStimulus(pack_all(1, 2), pack_all(3, 1), 1'b1, "accum");
      checkOutput("accum_re", int'(acc_re), 8);
      checkOutput("accum_im", int'(acc_im), 56);

      $display("[TB] overflow");
      applyStimulus(pack_all(-8, -8), pack_all(-8, 7), 1'b0, "ovf1");
      checkOutput("ovf1_re", int'(acc_re), 480);
      checkOutput("ovf1_im", int'(acc_im), 32);
      checkOutput("ovf1_ovf", int'(ovf), 0);
      applyStimulus(pack_all(-8, -8), pack_all(-8, 7), 1'b1, "ovf2");
`ifdef MAC_CPLX_SAT_EN
      checkOutput("ovf2_re", int'(acc_re), 511);
`else
      checkOutput("ovf2_re", int'(acc_re), -64);
`endif
      checkOutput("ovf2_im", int'(acc_im), 64);
      checkOutput("ovf2_ovf", int'(ovf), 1);

      $display("[TB] reset during RUN");
      @(negedge clk);
      #1;
      x_in  = pack_all(1, 2);
      y_in  = pack_all(3, 1);
      accum = 1'b1;
      start = 1'b1;
      @(negedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      checkOutput("midrun_acc_re", int'(acc_re), 0);
      checkOutput("midrun_acc_im", int'(acc_im), 0);
      checkOutput("midrun_ovf", int'(ovf), 0);
      checkOutput("midrun_done", int'(done), 0);
      @(negedge clk);
      #1;
      checkOutput("midrun_ready", int'(ready), 1);
      rst   = 1'b1;
      start = 1'b1;
      @(negedge clk);
      #1;
      start = 1'b0;
      wait_dones(1, "post_rst");
      repeat (2) @(negedge clk);
      #1;
      checkOutput("post_rst_re", int'(acc_re), 4);
      checkOutput("post_rst_im", int'(acc_im), 28);
      checkOutput("post_rst_ovf", int'(ovf), 0);

      $display("[TB] start while busy");
      base = done_cnt;
      @(negedge clk);
      #1;
      x_in  = pack_all(1, 2);
      y_in  = pack_all(3, 1);
      accum = 1'b0;
      start = 1'b1;
      @(negedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      #1;
      x_in  = pack_all(5, -3);
      accum = 1'b1;
      start = 1'b1;
      @(negedge clk);
      #1;
      start = 1'b0;
      for (int i = 0; i < 20 && done_cnt == base; i++) begin
         @(negedge clk);
         #1;
      end
      x_in  = pack_all(-7, 6);
      start = 1'b1;
      @(negedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      checkOutput("busy_dones", done_cnt - base, 1);
      checkOutput("busy_re", int'(acc_re), 4);
      checkOutput("busy_im", int'(acc_im), 28);
      checkOutput("busy_ready", int'(ready), 1);

      $display("[TB] back-to-back");
      @(negedge clk);
      #1;
      x_in     = pack_all(1, 2);
      y_in     = pack_all(3, 1);
      accum    = 1'b1;
      btb_mode = 1'b1;
      start    = 1'b1;
      wait_dones(3, "btb");
      start = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      btb_mode = 1'b0;
      checkOutput("btb_re", int'(acc_re), 16);
      checkOutput("btb_im", int'(acc_im), 112);

      $display("[TB] random operations");
      for (int n = 0; n < 6; n++)
         applyStimulus(rand_vec(), rand_vec(), 1'($urandom_range(0, 1)), "rand");

      checkOutput("sb_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
